// File: rtl/fifo_pkg.sv
// Shared constants and types for the programmable synchronous FIFO.
// Imported by the storage array and the FIFO top.
package fifo_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // A fill level must hold 0..DEPTH, hence one bit above the address
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [cnt_w(DEF_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog_sync.sv
// Single-clock FIFO with programmable almost flags, fill level, sticky
// error flags and a build-time registered / fall-through read mode.
module fifo_prog_sync
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic [ADDR_W:0]   i_alm_full_thr,
  input  logic [ADDR_W:0]   i_alm_empty_thr,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam fifo_mode_e MODE =
    (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_acc;
  logic              rd_acc;

  // Refusal is decided on the registered flags only, so a
  // simultaneous opposite access never rescues a blocked one.
  assign wr_acc = i_wren & ~o_full;
  assign rd_acc = i_rden & ~o_empty;

  always_comb begin
    count_nxt = o_count;
    unique case (1'b1)
      wr_acc & ~rd_acc: count_nxt = o_count + (ADDR_W+1)'(1);
      rd_acc & ~wr_acc: count_nxt = o_count - (ADDR_W+1)'(1);
      default:          count_nxt = o_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      o_count <= count_nxt;
      o_full  <= (count_nxt == FULL_CNT);
      o_empty <= (count_nxt == '0);
    end
  end

  // Set dominates clear so an error in the clearing cycle is kept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (i_wren & o_full) |
                     (o_overflow & ~i_clr_err);
      o_underflow <= (i_rden & o_empty) |
                     (o_underflow & ~i_clr_err);
    end
  end

  assign o_alm_full  = (o_count >= i_alm_full_thr);
  assign o_alm_empty = (o_count <= i_alm_empty_thr);

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (i_wrdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign o_rddata = o_empty ? '0 : ram_rdata;
  end else begin : g_std
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_q <= '0;
      end else if (rd_acc) begin
        rd_q <= ram_rdata;
      end
    end

    assign o_rddata = rd_q;
  end

endmodule

// File: tb/tb_fifo_prog_sync.sv
// Scoreboard bench for fifo_prog_sync: one registered-read and one
// fall-through instance, each checked against a queue model.
module tb_fifo_prog_sync;

  localparam int DW  = 128;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW:0]   thr_f;
  logic [AW:0]   thr_e;

  logic          s_wren, s_rden, s_clr;
  logic [DW-1:0] s_wrdata, s_rddata;
  logic          s_full, s_empty, s_afull, s_aempty;
  logic [AW:0]   s_count;
  logic          s_ovf, s_unf;

  logic          f_wren, f_rden, f_clr;
  logic [DW-1:0] f_wrdata, f_rddata;
  logic          f_full, f_empty, f_afull, f_aempty;
  logic [AW:0]   f_count;
  logic          f_ovf, f_unf;

  fifo_prog_sync #(.DATA_W(DW), .DEPTH(DEP), .FWFT(0)) u_std (
    .clk             (clk),
    .reset           (reset),
    .i_wren          (s_wren),
    .i_wrdata        (s_wrdata),
    .i_rden          (s_rden),
    .i_alm_full_thr  (thr_f),
    .i_alm_empty_thr (thr_e),
    .i_clr_err       (s_clr),
    .o_rddata        (s_rddata),
    .o_full          (s_full),
    .o_empty         (s_empty),
    .o_alm_full      (s_afull),
    .o_alm_empty     (s_aempty),
    .o_count         (s_count),
    .o_overflow      (s_ovf),
    .o_underflow     (s_unf)
  );

  fifo_prog_sync #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1)) u_fwft (
    .clk             (clk),
    .reset           (reset),
    .i_wren          (f_wren),
    .i_wrdata        (f_wrdata),
    .i_rden          (f_rden),
    .i_alm_full_thr  (thr_f),
    .i_alm_empty_thr (thr_e),
    .i_clr_err       (f_clr),
    .o_rddata        (f_rddata),
    .o_full          (f_full),
    .o_empty         (f_empty),
    .o_alm_full      (f_afull),
    .o_alm_empty     (f_aempty),
    .o_count         (f_count),
    .o_overflow      (f_ovf),
    .o_underflow     (f_unf)
  );

  logic [DW-1:0] mq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sbq[$];
  logic [DW-1:0] m_last;
  bit            m_ovf, m_unf;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic std_state();
    int c;
    c = mq.size();
    check("s_count",  DW'(s_count),  DW'(c));
    check("s_full",   DW'(s_full),   DW'(c == DEP));
    check("s_empty",  DW'(s_empty),  DW'(c == 0));
    check("s_afull",  DW'(s_afull),  DW'(c >= int'(thr_f)));
    check("s_aempty", DW'(s_aempty), DW'(c <= int'(thr_e)));
    check("s_ovf",    DW'(s_ovf),    DW'(m_ovf));
    check("s_unf",    DW'(s_unf),    DW'(m_unf));
    check("s_rddata", s_rddata,      m_last);
  endtask

  task automatic std_cyc(input bit wr, input logic [DW-1:0] d,
                         input bit rd, input bit clr);
    bit full_b, empty_b;
    full_b  = (mq.size() == DEP);
    empty_b = (mq.size() == 0);
    s_wren = wr; s_wrdata = d; s_rden = rd; s_clr = clr;
    if (rd && !empty_b) sbq.push_back(mq.pop_front());
    if (wr && !full_b) mq.push_back(d);
    m_ovf = (wr && full_b) || (m_ovf && !clr);
    m_unf = (rd && empty_b) || (m_unf && !clr);
    @(posedge clk); #1;
    s_wren = 1'b0; s_rden = 1'b0; s_clr = 1'b0;
    if (rd && !empty_b) m_last = sbq.pop_front();
    std_state();
  endtask

  task automatic fw_cyc(input bit wr, input logic [DW-1:0] d,
                        input bit rd);
    bit full_b, empty_b;
    full_b  = (fq.size() == DEP);
    empty_b = (fq.size() == 0);
    f_wren = wr; f_wrdata = d; f_rden = rd;
    if (rd && !empty_b) sbq.push_back(fq.pop_front());
    if (wr && !full_b) fq.push_back(d);
    if (rd && !empty_b) check("f_head", f_rddata, sbq.pop_front());
    @(posedge clk); #1;
    f_wren = 1'b0; f_rden = 1'b0;
    check("f_count", DW'(f_count), DW'(fq.size()));
    check("f_empty", DW'(f_empty), DW'(fq.size() == 0));
    check("f_full",  DW'(f_full),  DW'(fq.size() == DEP));
    if (fq.size() != 0) check("f_rddata", f_rddata, fq[0]);
    else                check("f_rddata", f_rddata, '0);
  endtask

  initial begin
    reset = 1'b0;
    thr_f = 5'd12; thr_e = 5'd3;
    s_wren = 0; s_rden = 0; s_clr = 0; s_wrdata = '0;
    f_wren = 0; f_rden = 0; f_clr = 0; f_wrdata = '0;
    m_last = '0; m_ovf = 0; m_unf = 0;
    #12;
    std_state();
    check("f_rst_empty", DW'(f_empty), DW'(1));
    check("f_rst_data",  f_rddata,     '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: fill 1..16, drain in order
    for (int i = 1; i <= 16; i++) std_cyc(1, DW'(i), 0, 0);
    for (int i = 0; i < 16; i++) std_cyc(0, '0, 1, 0);

    // 2: overflow on full, then clear, contents intact
    for (int i = 0; i < 16; i++) std_cyc(1, DW'(32'h100 + i), 0, 0);
    std_cyc(1, DW'(32'hDEAD), 0, 0);
    std_cyc(0, '0, 0, 1);
    for (int i = 0; i < 16; i++) std_cyc(0, '0, 1, 0);

    // 3: read+write on empty, read refused
    std_cyc(1, DW'(32'hA5), 1, 0);
    std_cyc(0, '0, 1, 0);
    std_cyc(0, '0, 0, 1);

    // 4: almost flags across 0..16, live threshold change
    for (int i = 1; i <= 13; i++) std_cyc(1, DW'(32'h400 + i), 0, 0);
    thr_f = 5'd14;
    #1;
    check("afull_live", DW'(s_afull), DW'(0));
    std_state();
    for (int i = 14; i <= 16; i++) std_cyc(1, DW'(32'h400 + i), 0, 0);
    for (int i = 0; i < 16; i++) std_cyc(0, '0, 1, 0);
    thr_f = 5'd12;

    // 5: fall-through instance
    fw_cyc(1, DW'(32'h55), 0);
    for (int i = 1; i < 8; i++) fw_cyc(1, DW'(32'h200 + i), 0);
    for (int i = 0; i < 40; i++) fw_cyc(1, DW'(32'h300 + i), 1);
    for (int i = 0; i < 8; i++) fw_cyc(0, '0, 1);
    fw_cyc(1, DW'(32'h66), 0);

    // 6: async reset mid-operation
    std_cyc(0, '0, 1, 0);
    for (int i = 0; i < 10; i++) std_cyc(1, DW'(32'h500 + i), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    mq.delete(); fq.delete();
    m_ovf = 0; m_unf = 0; m_last = '0;
    std_state();
    check("f_rst_mid", DW'(f_count), DW'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    std_cyc(1, DW'(32'h77), 0, 0);
    std_cyc(0, '0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
